// File: rtl/mult_booth_seq_pkg.sv
// Shared definitions for the sequential Booth multiplier: default width, FSM states, counter width.
package mult_booth_seq_pkg;

    localparam int unsigned DW    = 9;
    localparam int unsigned CNT_W = $clog2(DW + 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

endpackage

// File: rtl/mult_booth_step.sv
// One radix-2 Booth step: conditional add/subtract of M into A, then arithmetic right shift of {A,Q,q_1}.
module mult_booth_step #(
    parameter int unsigned DW = 9
) (
    input  logic [DW+1:0] a_i,
    input  logic [DW:0]   q_i,
    input  logic          q1_i,
    input  logic [DW:0]   m_i,
    output logic [DW+1:0] a_o,
    output logic [DW:0]   q_o,
    output logic          q1_o
);

    logic [DW+1:0] m_ext;
    logic [DW+1:0] sum;

    always_comb begin
        m_ext = {m_i[DW], m_i};
        case ({q_i[0], q1_i})
            2'b01:   sum = a_i + m_ext;
            2'b10:   sum = a_i - m_ext;
            default: sum = a_i;
        endcase
        a_o  = {sum[DW+1], sum[DW+1:1]};
        q_o  = {sum[0], q_i[DW:1]};
        q1_o = q_i[0];
    end

endmodule

// File: rtl/mult_booth_seq.sv
// Sequential radix-2 Booth multiplier, DW+1 steps per product.
// Define MULT_SIGNED_EN to honour signed_mode; otherwise operands are always zero-extended.
module mult_booth_seq #(
    parameter int unsigned DW = mult_booth_seq_pkg::DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_mode,
    input  logic [DW-1:0]   multiplicand,
    input  logic [DW-1:0]   multiplier,
    output logic            busy,
    output logic            ready,
    output logic [2*DW-1:0] product
);

    import mult_booth_seq_pkg::*;

    localparam int unsigned CW = $clog2(DW + 2);

    mult_state_t     state_q, state_d;
    logic [DW+1:0]   a_q, a_d;
    logic [DW:0]     q_q, q_d;
    logic            q1_q, q1_d;
    logic [DW:0]     m_q, m_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*DW-1:0] prod_q, prod_d;

    logic [DW+1:0]   step_a;
    logic [DW:0]     step_q;
    logic            step_q1;
    logic            sx_en;

`ifdef MULT_SIGNED_EN
    assign sx_en = signed_mode;
`else
    // Port kept for drop-in compatibility; forced to unsigned extension.
    assign sx_en = signed_mode & 1'b0;
`endif

    mult_booth_step #(.DW(DW)) u_step (
        .a_i  (a_q),
        .q_i  (q_q),
        .q1_i (q1_q),
        .m_i  (m_q),
        .a_o  (step_a),
        .q_o  (step_q),
        .q1_o (step_q1)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) state_d = IDLE;
                if (start) begin
                    a_d     = '0;
                    q_d     = {sx_en & multiplier[DW-1], multiplier};
                    q1_d    = 1'b0;
                    m_d     = {sx_en & multiplicand[DW-1], multiplicand};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = step_a;
                q_d   = step_q;
                q1_d  = step_q1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW)) begin
                    prod_d  = {step_a[DW-2:0], step_q};
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign ready   = (state_q == DONE);
    assign product = prod_q;

endmodule

// File: tb/tb_mult_booth_seq.sv
// Self-checking bench for mult_booth_seq (DW=9): vector table, corner sequences, random ops vs arithmetic model.
module tb_mult_booth_seq;

    localparam int unsigned W  = 9;
    localparam int unsigned PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          signed_mode;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic          busy;
    logic          ready;
    logic [PW-1:0] product;

    int   checks = 0;
    int   errors = 0;
    logic [PW-1:0] last_prod;
    time  ready_time;

    always #5 clk = ~clk;

    mult_booth_seq #(.DW(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .ready        (ready),
        .product      (product)
    );

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          s;
        logic [PW-1:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint pa, pb, p;
        logic   eff;
`ifdef MULT_SIGNED_EN
        eff = s;
`else
        eff = 1'b0 & s;
`endif
        pa = eff ? longint'($signed(a)) : longint'({1'b0, a});
        pb = eff ? longint'($signed(b)) : longint'({1'b0, b});
        p  = pa * pb;
        return p[PW-1:0];
    endfunction

    // Call at #1 after an edge with the DUT in IDLE or DONE; returns #1 after the ready edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [PW-1:0] exp, input bit poke, input string nm);
        int   lat;
        logic busy_ok, quiet_ok, hold_ok;
        multiplicand = a;
        multiplier   = b;
        signed_mode  = s;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        signed_mode  = 1'($urandom);
        busy_ok = 1'b1; quiet_ok = 1'b1; hold_ok = 1'b1; lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (ready !== 1'b0) quiet_ok = 1'b0;
            if (product !== last_prod) hold_ok = 1'b0;
            if (poke && k == 3) begin
                start        = 1'b1;
                multiplicand = W'($urandom);
                multiplier   = W'($urandom);
            end
            if (poke && k == 5) start = 1'b0;
            @(posedge clk); #1;
            if (ready === 1'b1) begin
                lat = k;
                break;
            end
        end
        ready_time = $time;
        chk({nm, " latency"}, 64'(lat), 64'(W + 1));
        chk({nm, " busy during run"}, 64'(busy_ok), 64'd1);
        chk({nm, " no early ready"}, 64'(quiet_ok && hold_ok), 64'd1);
        chk({nm, " busy low at ready"}, 64'(busy), 64'd0);
        chk({nm, " product"}, 64'(product), 64'(exp));
        last_prod = exp;
    endtask

    vec_t vecs[8];

    initial begin
        time t_first;
        logic abort_ok;

        vecs[0] = '{a: 9'd85,  b: 9'd127, s: 1'b0, exp: 18'd10795};
        vecs[1] = '{a: 9'd511, b: 9'd511, s: 1'b0, exp: 18'd261121};
        vecs[2] = '{a: 9'd0,   b: 9'd511, s: 1'b0, exp: 18'd0};
        vecs[3] = '{a: 9'd0,   b: 9'd511, s: 1'b1, exp: 18'd0};
`ifdef MULT_SIGNED_EN
        vecs[4] = '{a: 9'h1FF, b: 9'h1FF, s: 1'b1, exp: 18'd1};
        vecs[5] = '{a: 9'h100, b: 9'h100, s: 1'b1, exp: 18'd65536};
        vecs[6] = '{a: 9'h100, b: 9'h0FF, s: 1'b1, exp: 18'd196864};
        vecs[7] = '{a: 9'h0FF, b: 9'h100, s: 1'b1, exp: 18'd196864};
`else
        vecs[4] = '{a: 9'h1FF, b: 9'h1FF, s: 1'b1, exp: 18'd261121};
        vecs[5] = '{a: 9'h100, b: 9'h100, s: 1'b1, exp: 18'd65536};
        vecs[6] = '{a: 9'h100, b: 9'h0FF, s: 1'b1, exp: 18'd65280};
        vecs[7] = '{a: 9'h0FF, b: 9'h100, s: 1'b1, exp: 18'd65280};
`endif

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0;
        multiplicand = '0; multiplier = '0;
        last_prod = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset product", 64'(product), 64'd0);
        // rst together with start: reset must win.
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("rst beats start", 64'(busy), 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
            @(posedge clk); #1;
            chk($sformatf("vec%0d ready single cycle", i), 64'(ready), 64'd0);
        end

        // Back-to-back: second start accepted in the DONE cycle.
        run_op(9'd85, 9'd127, 1'b0, 18'd10795, 1'b0, "b2b first");
        t_first = ready_time;
        run_op(9'd85, 9'd85, 1'b0, 18'd7225, 1'b0, "b2b second");
        chk("b2b interval", 64'(ready_time - t_first), 64'((W + 2) * 10));
        @(posedge clk); #1;

        // Abort in the middle of RUN.
        multiplicand = 9'd300; multiplier = 9'd200; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort ready", 64'(ready), 64'd0);
        chk("abort product", 64'(product), 64'd0);
        abort_ok = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (ready !== 1'b0 || busy !== 1'b0) abort_ok = 1'b0;
        end
        chk("abort stays idle", 64'(abort_ok), 64'd1);
        last_prod = '0;
        run_op(9'd300, 9'd200, 1'b0, 18'd60000, 1'b0, "after abort");
        @(posedge clk); #1;

        // start pulses mid-RUN with fresh operands must be ignored.
        run_op(9'd123, 9'd45, 1'b0, 18'd5535, 1'b1, "start in run");
        @(posedge clk); #1;

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            run_op(ra, rb, rs, ref_mul(ra, rb, rs), 1'($urandom_range(0, 3) == 0),
                   $sformatf("rand%0d %0d*%0d s%0d", n, ra, rb, rs));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
